// File: rtl/vga_pkg.sv
// Shared VGA stream widths, text-box geometry and the bundled stream type.
package vga_pkg;
  localparam int COUNT_W = 11;
  localparam int RGB_W   = 12;
  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;
  localparam int COLS    = 16;
  localparam int ROWS    = 16;

  typedef struct packed {
    logic [COUNT_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [COUNT_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_if_t;
endpackage

// File: rtl/delay.sv
// WIDTH x CLK_DEL shift register, cleared by asynchronous active-low reset.
// CLK_DEL = 0 degenerates to a plain wire.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  generate
    if (CLK_DEL == 0) begin : g_wire
      assign o_dout = i_din;
    end else begin : g_sr
      logic [WIDTH-1:0] r_sr [CLK_DEL];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < CLK_DEL; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= i_din;
          for (int i = 1; i < CLK_DEL; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_dout = r_sr[CLK_DEL-1];
    end
  endgenerate
endmodule

// File: rtl/draw_rect_char.sv
// Text-box overlay: addresses the char/font ROMs and paints set glyph pixels over the stream.
// Latency 2+CHAR_ROM_LAT+FONT_ROM_LAT; DRAW_RECT_CHAR_BG_EN fills unset box pixels with BG_COLOR.
module draw_rect_char
  import vga_pkg::*;
#(
  parameter int         X_POS        = 336,
  parameter int         Y_POS        = 172,
  parameter logic [11:0] TEXT_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR    = 12'h222,
  parameter int         CHAR_ROM_LAT = 1,
  parameter int         FONT_ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COUNT_W-1:0] vcount_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic [COUNT_W-1:0] hcount_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [7:0]         char_pixels,
  output logic [7:0]         char_xy,
  output logic [3:0]         char_line,
  output logic [COUNT_W-1:0] vcount_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic [COUNT_W-1:0] hcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic [RGB_W-1:0]   rgb_out
);
  localparam int L = 2 + CHAR_ROM_LAT + FONT_ROM_LAT;
  localparam logic [COUNT_W-1:0] X0    = COUNT_W'(X_POS);
  localparam logic [COUNT_W-1:0] Y0    = COUNT_W'(Y_POS);
  localparam logic [COUNT_W-1:0] BOX_W = COUNT_W'(COLS * CHAR_W);
  localparam logic [COUNT_W-1:0] BOX_H = COUNT_W'(ROWS * CHAR_H);

  generate
    if (X_POS + COLS * CHAR_W > 2047) begin : g_bad_x_pos
      $error("draw_rect_char: X_POS + 128 exceeds the 11-bit hcount range");
    end
  endgenerate

  logic [COUNT_W-1:0] w_relx, w_rely;
  logic               w_in_box;
  logic [7:0]         r_char_xy;
  logic [3:0]         r_line;
  logic [3:0]         r_box_px;
  logic [3:0]         w_box_px_d;
  vga_if_t            w_stream_in, w_stream_d, w_out, r_out;
  logic               w_bit, w_bg_en;

  // Left of / above the box the subtraction wraps high, so one unsigned compare per axis suffices.
  assign w_relx   = hcount_in - X0;
  assign w_rely   = vcount_in - Y0;
  assign w_in_box = (w_relx < BOX_W) && (w_rely < BOX_H);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char_xy <= '0;
      r_line    <= '0;
      r_box_px  <= '0;
    end else if (w_in_box) begin
      r_char_xy <= {w_rely[7:4], w_relx[6:3]};
      r_line    <= w_rely[3:0];
      r_box_px  <= {1'b1, w_relx[2:0]};
    end else begin
      r_char_xy <= '0;
      r_line    <= '0;
      r_box_px  <= '0;
    end
  end

  assign w_stream_in = '{vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                         hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                         rgb: rgb_in};

  delay #(.WIDTH($bits(vga_if_t)), .CLK_DEL(L - 1)) u_stream_dly (
    .clk(clk), .rst_n(rst_n), .i_din(w_stream_in), .o_dout(w_stream_d));

  delay #(.WIDTH(4), .CLK_DEL(CHAR_ROM_LAT + FONT_ROM_LAT)) u_box_px_dly (
    .clk(clk), .rst_n(rst_n), .i_din(r_box_px), .o_dout(w_box_px_d));

  delay #(.WIDTH(4), .CLK_DEL(CHAR_ROM_LAT)) u_line_dly (
    .clk(clk), .rst_n(rst_n), .i_din(r_line), .o_dout(char_line));

`ifdef DRAW_RECT_CHAR_BG_EN
  assign w_bg_en = 1'b1;
`else
  assign w_bg_en = 1'b0;
`endif

  assign w_bit = char_pixels[3'd7 - w_box_px_d[2:0]];

  // Blanking wins over both text and background fill.
  always_comb begin
    w_out = w_stream_d;
    if (w_box_px_d[3] && !w_stream_d.hblnk && !w_stream_d.vblnk) begin
      if (w_bit)        w_out.rgb = TEXT_COLOR;
      else if (w_bg_en) w_out.rgb = BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= '0;
    else        r_out <= w_out;
  end

  assign char_xy    = r_char_xy;
  assign vcount_out = r_out.vcount;
  assign vsync_out  = r_out.vsync;
  assign vblnk_out  = r_out.vblnk;
  assign hcount_out = r_out.hcount;
  assign hsync_out  = r_out.hsync;
  assign hblnk_out  = r_out.hblnk;
  assign rgb_out    = r_out.rgb;
endmodule
